// File: rtl/ej32_fetch_if.sv
// Fetch-stage bus bundle: program-memory read port, decoder redirect input,
// and the per-instruction transfer to the decoder.
interface ej32_fetch_if #(
   parameter int unsigned ASZ = 17
);
   logic           mem_en;
   logic [ASZ-1:0] mem_a;
   logic [7:0]     mem_d;
   logic           br_en;
   logic [ASZ-1:0] br_a;
   logic           dec_valid;
   logic           dec_ready;
   logic [7:0]     dec_op;
   logic [31:0]    dec_arg;
   logic [2:0]     dec_len;
   logic [ASZ-1:0] dec_pc;
   logic           dec_err;

   // Fetch-stage view
   modport master (
      output mem_en, mem_a,
      input  mem_d,
      input  br_en, br_a,
      output dec_valid,
      input  dec_ready,
      output dec_op, dec_arg, dec_len, dec_pc, dec_err
   );

   // Memory / decoder view
   modport slave (
      input  mem_en, mem_a,
      output mem_d,
      output br_en, br_a,
      input  dec_valid,
      output dec_ready,
      input  dec_op, dec_arg, dec_len, dec_pc, dec_err
   );
endinterface

// File: rtl/ej32_fetch.sv
// eJ32 bytecode fetch / pre-decode: byte queue fed one byte per cycle from
// program memory, whole instructions (opcode + big-endian operands) handed
// to the decoder in one transfer, flushed and restarted on branch redirect.
module ej32_fetch #(
   parameter int unsigned    ASZ    = 17,
   parameter int unsigned    QD     = 8,
   parameter logic [ASZ-1:0] RST_PC = '0
) (
   input logic          clk,
   input logic          rst,
   ej32_fetch_if.master bus
);
   localparam int unsigned IW = $clog2(QD);
   localparam int unsigned CW = $clog2(QD + 1);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t         state, state_nx;
   logic [7:0]     q_d [QD];
   logic [ASZ-1:0] q_a [QD];
   logic [IW-1:0]  head, tail;
   logic [CW-1:0]  count;
   logic [CW-1:0]  pop_n;
   logic [ASZ-1:0] ptr;
   logic           rd;
   logic [ASZ-1:0] rd_a;
   logic           push, pop;
   logic [2:0]     len;
   logic           err;
   logic [7:0]     b1, b2, b3, b4;

   // Queue index advanced by k entries, wrapping at QD (k never exceeds QD)
   function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= QD) s = s - QD;
      return IW'(s);
   endfunction

   // Operand byte count for each opcode
   function automatic logic [2:0] op_len(input logic [7:0] op);
      logic [2:0] l;
      l = 3'd0;
      case (op) inside
         8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9, 8'hbc:
            l = 3'd1;
         8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8],
         8'hbb, 8'hbd, 8'hc0, 8'hc1, 8'hc6, 8'hc7, 8'hca:
            l = 3'd2;
         8'hc5:
            l = 3'd3;
         8'hb9, 8'hba, 8'hc8, 8'hc9, 8'hdb:
            l = 3'd4;
         default:
            l = 3'd0;
      endcase
      return l;
   endfunction

   // tableswitch, lookupswitch, wide and op_err cannot be framed here
   function automatic logic op_bad(input logic [7:0] op);
      return (op == 8'haa) || (op == 8'hab) || (op == 8'hc4) || (op == 8'hff);
   endfunction

   assign len  = op_len(q_d[head]);
   assign err  = op_bad(q_d[head]);
   assign b1   = q_d[wrap(head, 1)];
   assign b2   = q_d[wrap(head, 2)];
   assign b3   = q_d[wrap(head, 3)];
   assign b4   = q_d[wrap(head, 4)];
   assign pop  = bus.dec_valid && bus.dec_ready;
   assign push = rd && !bus.br_en;
   assign pop_n = pop ? (CW'(len) + CW'(1)) : '0;

   assign bus.mem_a   = ptr;
   assign bus.dec_op  = q_d[head];
   assign bus.dec_pc  = q_a[head];
   assign bus.dec_len = len;
   assign bus.dec_err = err;

   // Right-justified big-endian operand assembly
   always_comb begin : arg_build
      bus.dec_arg = '0;
      case (len)
         3'd1:    bus.dec_arg = {24'd0, b1};
         3'd2:    bus.dec_arg = {16'd0, b1, b2};
         3'd3:    bus.dec_arg = {8'd0, b1, b2, b3};
         3'd4:    bus.dec_arg = {b1, b2, b3, b4};
         default: bus.dec_arg = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin : fsm_reg
      if (rst) state <= BOOT;
      else     state <= state_nx;
   end

   // Next state, fetch strobe and presentation; redirect overrides everything
   always_comb begin : fsm_comb
      state_nx      = state;
      bus.mem_en    = 1'b0;
      bus.dec_valid = 1'b0;
      case (state)
         BOOT: state_nx = RUN;
         RUN: begin
            bus.mem_en    = (32'(count) + 32'(rd)) < QD;
            bus.dec_valid = 32'(count) >= (32'(len) + 32'd1);
            if (bus.dec_valid && bus.dec_ready && err) state_nx = HALT;
         end
         HALT: state_nx = HALT;
         default: state_nx = BOOT;
      endcase
      if (bus.br_en) begin
         bus.mem_en    = 1'b0;
         bus.dec_valid = 1'b0;
         state_nx      = RUN;
      end
   end

   // Fetch pointer, read-in-flight tracking and byte queue
   always_ff @(posedge clk or posedge rst) begin : queue_reg
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         ptr   <= RST_PC;
         rd    <= 1'b0;
         rd_a  <= RST_PC;
         for (int unsigned i = 0; i < QD; i++) begin
            q_d[IW'(i)] <= '0;
            q_a[IW'(i)] <= RST_PC;
         end
      end else begin
         rd   <= bus.mem_en;
         rd_a <= ptr;
         if (bus.br_en) begin
            // the byte returning this cycle belongs to the old stream: dropped
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ptr   <= bus.br_a;
         end else begin
            if (bus.mem_en) ptr <= ptr + ASZ'(1);
            if (push) begin
               q_d[tail] <= bus.mem_d;
               q_a[tail] <= rd_a;
               tail      <= wrap(tail, 1);
            end
            if (pop) head <= wrap(head, 32'(len) + 32'd1);
            count <= count + CW'(push) - pop_n;
         end
      end
   end
endmodule

// File: tb/tb_ej32_fetch.sv
// Directed bench for ej32_fetch: table of instruction encodings with expected
// transfers, plus hand-written sequences for reset, backpressure, redirect
// with a stale read, unsupported-opcode halt and asynchronous reset.
module tb_ej32_fetch;
   localparam int unsigned ASZ = 17;
   localparam int unsigned QD  = 8;

   logic clk = 1'b0;
   logic rst;

   ej32_fetch_if #(.ASZ(ASZ)) bus ();

   ej32_fetch #(.ASZ(ASZ), .QD(QD), .RST_PC(17'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Program memory: data valid the cycle after the address
   logic [7:0] mem [1024];
   always @(posedge clk) bus.mem_d <= mem[bus.mem_a[9:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]     op;
      logic [31:0]    arg;
      logic [2:0]     len;
      logic [ASZ-1:0] pc;
      logic           err;
      int             cyc;
   } xfer_t;

   xfer_t xq[$];

   // Record every accepted transfer
   always @(negedge clk) begin
      xfer_t x;
      if (bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
         x.op  = bus.dec_op;
         x.arg = bus.dec_arg;
         x.len = bus.dec_len;
         x.pc  = bus.dec_pc;
         x.err = bus.dec_err;
         x.cyc = cyc;
         xq.push_back(x);
      end
   end

   typedef struct {
      int          n;
      logic [39:0] b;
      logic [7:0]  op;
      logic [31:0] arg;
      logic [2:0]  len;
      logic        err;
   } vec_t;

   localparam int NV = 14;
   vec_t vt [NV];

   int total = 0;
   int bad   = 0;

   function automatic vec_t mk(input int n, input logic [39:0] b, input logic [7:0] op,
                               input logic [31:0] arg, input logic [2:0] len, input logic err);
      vec_t v;
      v.n = n; v.b = b; v.op = op; v.arg = arg; v.len = len; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_x(input string name, input int idx, input logic [7:0] op,
                        input logic [31:0] arg, input logic [2:0] len,
                        input logic [ASZ-1:0] pc, input logic err);
      if (idx >= xq.size()) begin
         total++;
         bad++;
         $display("FAIL %s: transfer %0d missing, only %0d recorded", name, idx, xq.size());
      end else begin
         chk(name, {3'b0, xq[idx].op, xq[idx].arg, xq[idx].len, xq[idx].pc, xq[idx].err},
             {3'b0, op, arg, len, pc, err});
      end
   endtask

   task automatic wait_xfers(input int base, input int n, input int budget, input string name);
      int k = 0;
      while (xq.size() < base + n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (xq.size() < base + n) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, got %0d transfers want %0d", name, xq.size() - base, n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_mem_en"},    64'(bus.mem_en),    64'(0));
      chk({tag, "_mem_a"},     64'(bus.mem_a),     64'(0));
      chk({tag, "_dec_valid"}, 64'(bus.dec_valid), 64'(0));
      chk({tag, "_dec_op"},    64'(bus.dec_op),    64'(0));
      chk({tag, "_dec_arg"},   64'(bus.dec_arg),   64'(0));
      chk({tag, "_dec_len"},   64'(bus.dec_len),   64'(0));
      chk({tag, "_dec_pc"},    64'(bus.dec_pc),    64'(0));
      chk({tag, "_dec_err"},   64'(bus.dec_err),   64'(0));
   endtask

   // One-cycle redirect pulse; base marks where new transfers start in xq
   task automatic redirect(input logic [ASZ-1:0] a, input logic ready, output int base);
      step();
      bus.br_en     = 1'b1;
      bus.br_a      = a;
      bus.dec_ready = ready;
      base          = xq.size();
      step();
      bus.br_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      int addr;
      int n_rd;
      int unstable;
      int gaps;
      int busy;
      logic found;
      logic [ASZ-1:0] pc;

      rst           = 1'b1;
      bus.br_en     = 1'b0;
      bus.br_a      = '0;
      bus.dec_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

      vt[0]  = mk(5, 40'hdb_12_34_56_78, 8'hdb, 32'h12345678, 3'd4, 1'b0);
      vt[1]  = mk(2, 40'h10_7f_00_00_00, 8'h10, 32'h0000007f, 3'd1, 1'b0);
      vt[2]  = mk(3, 40'h11_12_34_00_00, 8'h11, 32'h00001234, 3'd2, 1'b0);
      vt[3]  = mk(4, 40'hc5_ab_cd_02_00, 8'hc5, 32'h00abcd02, 3'd3, 1'b0);
      vt[4]  = mk(1, 40'h00_00_00_00_00, 8'h00, 32'h00000000, 3'd0, 1'b0);
      vt[5]  = mk(2, 40'h15_03_00_00_00, 8'h15, 32'h00000003, 3'd1, 1'b0);
      vt[6]  = mk(3, 40'h84_01_ff_00_00, 8'h84, 32'h000001ff, 3'd2, 1'b0);
      vt[7]  = mk(2, 40'h36_05_00_00_00, 8'h36, 32'h00000005, 3'd1, 1'b0);
      vt[8]  = mk(5, 40'hb9_01_02_03_04, 8'hb9, 32'h01020304, 3'd4, 1'b0);
      vt[9]  = mk(1, 40'h60_00_00_00_00, 8'h60, 32'h00000000, 3'd0, 1'b0);
      vt[10] = mk(3, 40'ha7_00_03_00_00, 8'ha7, 32'h00000003, 3'd2, 1'b0);
      vt[11] = mk(3, 40'hca_00_10_00_00, 8'hca, 32'h00000010, 3'd2, 1'b0);
      vt[12] = mk(2, 40'hbc_0a_00_00_00, 8'hbc, 32'h0000000a, 3'd1, 1'b0);
      vt[13] = mk(1, 40'hc4_00_00_00_00, 8'hc4, 32'h00000000, 3'd0, 1'b1);

      mem[0] = 8'h10; mem[1] = 8'h7f; mem[2] = 8'h59;
      mem[4] = 8'ha7; mem[5] = 8'h00; mem[6] = 8'h08; mem[7] = 8'h60; mem[8] = 8'h61;
      mem[32] = 8'h04; mem[33] = 8'h05;
      mem[64] = 8'h10; mem[65] = 8'h22;
      addr = 256;
      for (int i = 0; i < NV; i++)
         for (int k = 0; k < vt[i].n; k++) begin
            mem[addr] = vt[i].b[39-8*k -: 8];
            addr++;
         end

      // Reset state and first instructions from RST_PC
      @(posedge clk);
      step();
      chk_reset("reset");
      base          = xq.size();
      rst           = 1'b0;
      bus.dec_ready = 1'b1;
      wait_xfers(base, 2, 30, "boot_xfers");
      chk_x("boot_bipush", base,     8'h10, 32'h7f, 3'd1, 17'h0, 1'b0);
      chk_x("boot_dup",    base + 1, 8'h59, 32'h0,  3'd0, 17'h2, 1'b0);

      // Table of encodings at 0x100, streamed back to back
      redirect(17'h100, 1'b1, base);
      wait_xfers(base, NV, 150, "table_xfers");
      pc = 17'h100;
      for (int i = 0; i < NV; i++) begin
         chk_x($sformatf("table_%0d_op%0h", i, vt[i].op), base + i,
               vt[i].op, vt[i].arg, vt[i].len, pc, vt[i].err);
         pc = pc + ASZ'(vt[i].n);
      end

      // Backpressure on a nop stream: exactly QD reads, head held stable
      redirect(17'h300, 1'b0, base);
      n_rd = 0;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_en) n_rd++;
         if (bus.dec_valid && (bus.dec_pc !== 17'h300 || bus.dec_op !== 8'h00)) unstable++;
      end
      chk("bp_reads",     64'(n_rd),          64'(QD));
      chk("bp_mem_en",    64'(bus.mem_en),    64'(0));
      chk("bp_valid",     64'(bus.dec_valid), 64'(1));
      chk("bp_pc",        64'(bus.dec_pc),    64'(17'h300));
      chk("bp_unstable",  64'(unstable),      64'(0));
      chk("bp_no_xfer",   64'(xq.size()),     64'(base));
      step();
      bus.dec_ready = 1'b1;
      base = xq.size();
      wait_xfers(base, 12, 40, "bp_drain");
      gaps = 0;
      for (int i = 0; i < 12 && base + i < xq.size(); i++) begin
         chk($sformatf("bp_drain_pc_%0d", i), 64'(xq[base + i].pc), 64'(17'h300 + i));
         if (i > 0 && xq[base + i].cyc != xq[base + i - 1].cyc + 1) gaps++;
      end
      chk("bp_drain_gaps", 64'(gaps), 64'(0));

      // Redirect right after goto while the next byte is in flight
      redirect(17'h4, 1'b1, base);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.dec_valid && bus.dec_pc == 17'h4) found = 1'b1;
      end
      chk("goto_seen", 64'(found), 64'(1));
      chk("goto_read_in_flight", 64'(bus.mem_en), 64'(1));
      step();
      bus.br_en = 1'b1;
      bus.br_a  = 17'h20;
      base      = xq.size();
      chk_x("goto_xfer", base - 1, 8'ha7, 32'h8, 3'd2, 17'h4, 1'b0);
      @(negedge clk);
      chk("br_forces_invalid", 64'(bus.dec_valid), 64'(0));
      step();
      bus.br_en = 1'b0;
      wait_xfers(base, 2, 20, "stale_xfers");
      chk_x("stale_first",  base,     8'h04, 32'h0, 3'd0, 17'h20, 1'b0);
      chk_x("stale_second", base + 1, 8'h05, 32'h0, 3'd0, 17'h21, 1'b0);

      // Unsupported opcode halts fetch until redirected
      mem[0] = 8'haa;
      redirect(17'h0, 1'b1, base);
      wait_xfers(base, 1, 20, "halt_xfer");
      chk_x("halt_tableswitch", base, 8'haa, 32'h0, 3'd0, 17'h0, 1'b1);
      busy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.mem_en || bus.dec_valid) busy++;
      end
      chk("halt_idle", 64'(busy), 64'(0));
      redirect(17'h40, 1'b1, base);
      @(negedge clk);
      chk("halt_resume_en", 64'(bus.mem_en), 64'(1));
      chk("halt_resume_a",  64'(bus.mem_a),  64'(17'h40));
      wait_xfers(base, 1, 20, "resume_xfer");
      chk_x("resume_bipush", base, 8'h10, 32'h22, 3'd1, 17'h40, 1'b0);

      // Asynchronous reset in the clock-low phase of a running burst
      repeat (5) step();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_reset("async");
      step();
      chk("async_held_mem_en", 64'(bus.mem_en), 64'(0));
      rst  = 1'b0;
      base = xq.size();
      @(negedge clk);
      chk("async_boot_idle", 64'(bus.mem_en), 64'(0));
      @(negedge clk);
      chk("async_fetch_en", 64'(bus.mem_en), 64'(1));
      chk("async_fetch_a",  64'(bus.mem_a),  64'(0));
      wait_xfers(base, 1, 20, "async_xfer");
      chk_x("async_first", base, 8'haa, 32'h0, 3'd0, 17'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
